traffic_phase_ctrl: RTL and testbench
=====================================

Name: traffic_phase_ctrl

Overview:
Phase sequencer for a four-approach intersection. It drives the 4-bit phase code consumed by the phase timer and advances only when the timer returns `expired`. It selects approaches round-robin, skips empty approaches, and chooses primary or extended green from congestion sensors. It also decodes per-approach red/yellow/green lamp outputs.

Parameters:
- WDOG_LIMIT, default 63: max cycles any phase may persist without `expired` before fault.
- NUM_DIR, default 4: number of approaches; fixed at 4 by the phase encoding, and other values are unsupported.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- expired  in  1  timer expiry pulse, sampled at posedge
- car_present  in  4  bit d = vehicle waiting on approach d
- heavy  in  4  bit d = congestion on approach d (requests extended green)
- state  out  4  registered phase code to timer
- green  out  4  lamp per approach, one-hot or zero
- yellow  out  4  lamp per approach, one-hot or zero
- red  out  4  lamp per approach, complement of (green|yellow)
- phase_dir  out  2  approach currently served (last served while in ALL_RED)
- fault  out  1  sticky watchdog fault

Behaviour:
- Phase codes: ALL_RED=0. For approach d=0..3: GREEN_P=3d+1, GREEN_X=3d+2, YELLOW=3d+3. Codes 13-15 are never driven.
- Reset (rst=0 at posedge):
  - state=0, green=0, yellow=0, red=4'hF, phase_dir=0, fault=0.
  - rr pointer=0, watchdog=0, blank flag set.
- Blanking: `expired` is ignored in the first cycle after any change of `state`, including after reset, because the timer reloads from `state`.
- Transitions, taken at a posedge with expired=1 and blank clear:
  - ALL_RED: search car_present starting at the rr pointer, wrapping 3->0. On the first hit d, go to GREEN_X if heavy[d] else GREEN_P; set phase_dir=d. If no car anywhere, stay ALL_RED. car_present and heavy are sampled at this same edge.
  - GREEN_P or GREEN_X of d: go to YELLOW of d. heavy changes during green are ignored.
  - YELLOW of d: go to ALL_RED; rr pointer = (d+1) mod 4.
- Latency: state changes on the same posedge that samples `expired`. Lamp outputs are registered alongside `state`, with zero relative skew.
- Exactly one approach is non-red at any time. ALL_RED always separates two different greens.
- Watchdog:
  - 6-bit counter, cleared on any state change or any accepted `expired`, otherwise incremented.
  - Reaching WDOG_LIMIT sets fault=1 and forces state=0 and all red.
  - The counter saturates. fault stays set and state stays 0 until reset; `expired` is ignored while fault=1.
- Reset mid-phase: reset has priority over every event, and the next cycle is reset state.

Optional Feature:
EMERGENCY_PREEMPT_EN
- When defined, adds port `emg_req  in  4`, one bit per approach requesting preemption.
  - In GREEN_P or GREEN_X of d with emg_req having a bit set other than d: go to YELLOW of d at the next posedge, without waiting for `expired`.
  - In ALL_RED with any emg_req bit set: on the next accepted `expired`, serve the lowest-indexed requesting approach e, always as GREEN_X. The rr pointer is left unchanged by the preempted service.
  - emg_req[d] while green on d: green continues normally.
- When undefined: the port is absent and behaviour is exactly as above.

Decomposition:
- Package traffic_pkg holds:
  - phase-code constants ST_ALL_RED, ST_GREEN_P, ST_GREEN_X, ST_YELLOW offsets;
  - an encode function (dir, kind) -> code and a decode function code -> (dir, kind);
  - the NUM_DIR constant.
- The timer block shares the same package.
- One sub-module, rr_dir_select: combinational round-robin picker. Inputs are a request vector and a pointer; outputs are a hit flag and a 2-bit index. It is reused for the emergency lowest-index pick with the pointer tied to 0.

Test Plan:
- Reset, car_present=4'b0001, heavy=0, pulse expired every 5 cycles -> state 0 -> 1 -> 3 -> 0; green=0001 then yellow=0001, then red=F.
- car_present=4'b1010, heavy=4'b1000, pointer=0 -> serves dir1 (state 4), then ALL_RED, then dir3 as GREEN_X (state 11).
- car_present=0 with expired every cycle -> state stays 0, red=F, no fault.
- Hold expired=0 for 63 cycles in state 4 -> fault=1, state=0, red=F; later expired pulses have no effect until rst=0.
- expired asserted in the cycle right after a state change -> ignored; state holds until the next pulse.
- With EMERGENCY_PREEMPT_EN: in state 1, set emg_req=4'b0100 -> state 3 next cycle, then 0, then state 8 (GREEN_X dir2) on the next expired.

Source files
------------

// File: rtl/traffic_pkg.sv
// ============================================================================
// Module   : traffic_pkg
// Brief    : Shared phase-code constants, phase kinds and encode/decode
//            helpers for the intersection sequencer and its phase timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

  localparam int NUM_DIR = 4;

  // Phase code layout: 0 is all-red, approach d owns codes 3d+1 .. 3d+3
  localparam logic [3:0] ST_ALL_RED = 4'd0;
  localparam logic [3:0] ST_GREEN_P = 4'd1;
  localparam logic [3:0] ST_GREEN_X = 4'd2;
  localparam logic [3:0] ST_YELLOW  = 4'd3;

  typedef enum logic [1:0] {
    K_RED     = 2'd0,
    K_GREEN_P = 2'd1,
    K_GREEN_X = 2'd2,
    K_YELLOW  = 2'd3
  } kind_t;

  typedef struct packed {
    logic [1:0] dir;
    kind_t      kind;
  } phase_t;

  // Build a phase code from an approach index and a phase kind
  function automatic logic [3:0] encode(input logic [1:0] dir, input kind_t kind);
    logic [3:0] base;
    base = {1'b0, dir, 1'b0} + {2'b00, dir};
    case (kind)
      K_GREEN_P: encode = base + ST_GREEN_P;
      K_GREEN_X: encode = base + ST_GREEN_X;
      K_YELLOW:  encode = base + ST_YELLOW;
      default:   encode = ST_ALL_RED;
    endcase
  endfunction

  // Split a phase code back into approach and kind; unused codes read as all-red
  function automatic phase_t decode(input logic [3:0] code);
    phase_t p;
    case (code)
      4'd1:    p = '{dir: 2'd0, kind: K_GREEN_P};
      4'd2:    p = '{dir: 2'd0, kind: K_GREEN_X};
      4'd3:    p = '{dir: 2'd0, kind: K_YELLOW};
      4'd4:    p = '{dir: 2'd1, kind: K_GREEN_P};
      4'd5:    p = '{dir: 2'd1, kind: K_GREEN_X};
      4'd6:    p = '{dir: 2'd1, kind: K_YELLOW};
      4'd7:    p = '{dir: 2'd2, kind: K_GREEN_P};
      4'd8:    p = '{dir: 2'd2, kind: K_GREEN_X};
      4'd9:    p = '{dir: 2'd2, kind: K_YELLOW};
      4'd10:   p = '{dir: 2'd3, kind: K_GREEN_P};
      4'd11:   p = '{dir: 2'd3, kind: K_GREEN_X};
      4'd12:   p = '{dir: 2'd3, kind: K_YELLOW};
      default: p = '{dir: 2'd0, kind: K_RED};
    endcase
    decode = p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_phase_ctrl_rr_dir_select.sv
// ============================================================================
// Module   : rr_dir_select
// Brief    : Combinational round-robin picker over four request bits,
//            searching upward from a pointer and wrapping 3 -> 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_dir_select (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       hit,
  output logic [1:0] idx
);

  logic [1:0] w_cand;

  // First requesting approach at or after the pointer
  always_comb begin
    hit    = 1'b0;
    idx    = 2'd0;
    w_cand = 2'd0;
    for (int i = 0; i < 4; i++) begin
      w_cand = ptr + 2'(i);
      if (!hit && req[w_cand]) begin
        hit = 1'b1;
        idx = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
// ============================================================================
// Module   : traffic_phase_ctrl
// Brief    : Four-approach phase sequencer with round-robin service,
//            empty-approach skipping, extended green on congestion, lamp
//            decode and a sticky watchdog fault.
//            Optional macro EMERGENCY_PREEMPT_EN adds emg_req preemption.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int WDOG_LIMIT = 63,
  parameter int NUM_DIR    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               expired,
  input  logic [NUM_DIR-1:0] car_present,
  input  logic [NUM_DIR-1:0] heavy,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic [NUM_DIR-1:0] emg_req,
`endif
  output logic [3:0]         state,
  output logic [3:0]         green,
  output logic [3:0]         yellow,
  output logic [3:0]         red,
  output logic [1:0]         phase_dir,
  output logic               fault
);

  localparam logic [5:0] c_wdog_lim = 6'(WDOG_LIMIT);

  logic [1:0] r_rr;
  logic [5:0] r_wdog;
  logic       r_blank;
  logic       r_preempt;

  phase_t     w_cur;
  phase_t     w_nd;
  logic [3:0] w_nxt;
  logic [1:0] w_nxt_dir;
  logic [1:0] w_nxt_rr;
  logic       w_nxt_pre;
  logic       w_acc;
  logic       w_cut;
  logic       w_chg;
  logic       w_trip;
  logic [5:0] w_wd_inc;
  logic [3:0] w_grn;
  logic [3:0] w_yel;
  logic       w_rr_hit;
  logic [1:0] w_rr_idx;

  assign w_cur = decode(state);
  // The timer reloads from state, so its expiry is meaningless right after a change
  assign w_acc = expired & ~r_blank & ~fault;

  rr_dir_select u_rr (
    .req (car_present),
    .ptr (r_rr),
    .hit (w_rr_hit),
    .idx (w_rr_idx)
  );

`ifdef EMERGENCY_PREEMPT_EN
  logic       w_emg_hit;
  logic [1:0] w_emg_idx;

  rr_dir_select u_emg (
    .req (emg_req),
    .ptr (2'd0),
    .hit (w_emg_hit),
    .idx (w_emg_idx)
  );

  // A request from any other approach cuts the current green short
  assign w_cut = ((w_cur.kind == K_GREEN_P) || (w_cur.kind == K_GREEN_X)) &&
                 (|(emg_req & ~(4'b0001 << w_cur.dir)));
`else
  assign w_cut = 1'b0;
`endif

  // Next phase, served approach, round-robin pointer and preemption marker
  always_comb begin
    w_nxt     = state;
    w_nxt_dir = phase_dir;
    w_nxt_rr  = r_rr;
    w_nxt_pre = r_preempt;
    case (w_cur.kind)
      K_RED: begin
        if (w_acc) begin
`ifdef EMERGENCY_PREEMPT_EN
          if (w_emg_hit) begin
            w_nxt     = encode(w_emg_idx, K_GREEN_X);
            w_nxt_dir = w_emg_idx;
            w_nxt_pre = 1'b1;
          end else
`endif
          if (w_rr_hit) begin
            w_nxt     = encode(w_rr_idx, heavy[w_rr_idx] ? K_GREEN_X : K_GREEN_P);
            w_nxt_dir = w_rr_idx;
            w_nxt_pre = 1'b0;
          end
        end
      end
      K_GREEN_P, K_GREEN_X: begin
        if (w_acc || w_cut) w_nxt = encode(w_cur.dir, K_YELLOW);
      end
      K_YELLOW: begin
        if (w_acc) begin
          w_nxt = ST_ALL_RED;
          // A preempted service must not disturb the fairness rotation
          if (!r_preempt) w_nxt_rr = w_cur.dir + 2'd1;
          w_nxt_pre = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Watchdog step and lamp decode of the upcoming phase
  always_comb begin
    w_chg    = (w_nxt != state);
    w_wd_inc = (r_wdog == 6'h3F) ? r_wdog : r_wdog + 6'd1;
    w_trip   = ~w_chg & ~w_acc & (w_wd_inc >= c_wdog_lim);
    w_nd     = decode(w_nxt);
    w_grn    = ((w_nd.kind == K_GREEN_P) || (w_nd.kind == K_GREEN_X)) ?
               (4'b0001 << w_nd.dir) : 4'b0000;
    w_yel    = (w_nd.kind == K_YELLOW) ? (4'b0001 << w_nd.dir) : 4'b0000;
  end

  // Phase register with lamps registered alongside; fault latches until reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_ALL_RED;
      green     <= 4'h0;
      yellow    <= 4'h0;
      red       <= 4'hF;
      phase_dir <= 2'd0;
      fault     <= 1'b0;
      r_rr      <= 2'd0;
      r_wdog    <= 6'd0;
      r_blank   <= 1'b1;
      r_preempt <= 1'b0;
    end else if (!fault) begin
      if (w_trip) begin
        fault     <= 1'b1;
        state     <= ST_ALL_RED;
        green     <= 4'h0;
        yellow    <= 4'h0;
        red       <= 4'hF;
        r_wdog    <= w_wd_inc;
        r_blank   <= 1'b1;
        r_preempt <= 1'b0;
      end else begin
        state     <= w_nxt;
        green     <= w_grn;
        yellow    <= w_yel;
        red       <= ~(w_grn | w_yel);
        phase_dir <= w_nxt_dir;
        r_rr      <= w_nxt_rr;
        r_preempt <= w_nxt_pre;
        r_blank   <= w_chg;
        r_wdog    <= (w_chg || w_acc) ? 6'd0 : w_wd_inc;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
// ============================================================================
// Module   : tb_traffic_phase_ctrl
// Brief    : Scoreboard bench for traffic_phase_ctrl; directed stimulus pushes
//            hand-computed phase records, a monitor pops one per phase change.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       expired = 1'b0;
  logic [3:0] car_present = 4'h0;
  logic [3:0] heavy = 4'h0;
`ifdef EMERGENCY_PREEMPT_EN
  logic [3:0] emg_req = 4'h0;
`endif
  logic [3:0] state;
  logic [3:0] green;
  logic [3:0] yellow;
  logic [3:0] red;
  logic [1:0] phase_dir;
  logic       fault;

  traffic_phase_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .expired     (expired),
    .car_present (car_present),
    .heavy       (heavy),
`ifdef EMERGENCY_PREEMPT_EN
    .emg_req     (emg_req),
`endif
    .state       (state),
    .green       (green),
    .yellow      (yellow),
    .red         (red),
    .phase_dir   (phase_dir),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] g;
    logic [3:0] y;
    logic [3:0] r;
    logic [1:0] dir;
    logic       f;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic [3:0] g, input logic [3:0] y,
                      input logic [3:0] r, input logic [1:0] dir, input logic f);
    exp_t e;
    e.st = st; e.g = g; e.y = y; e.r = r; e.dir = dir; e.f = f;
    q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    expired = 1'b1;
    @(negedge clk);
    expired = 1'b0;
  endtask

  // Monitor: every phase change consumes one expected record
  initial begin
    logic [3:0] prev;
    exp_t       e;
    repeat (2) @(negedge clk);
    prev = state;
    forever begin
      @(negedge clk);
      if (state !== prev) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_change: state=%0d with no expected record (t=%0t)", state, $time);
        end else begin
          e = q.pop_front();
          check("mon_state", state, e.st);
          check("mon_green", green, e.g);
          check("mon_yellow", yellow, e.y);
          check("mon_red", red, e.r);
          check("mon_dir", phase_dir, e.dir);
          check("mon_fault", fault, e.f);
        end
        prev = state;
      end
    end
  end

  initial begin
    // Reset values
    cyc(3);
    check("rst_state", state, 0);
    check("rst_green", green, 0);
    check("rst_yellow", yellow, 0);
    check("rst_red", red, 4'hF);
    check("rst_dir", phase_dir, 0);
    check("rst_fault", fault, 0);

    // First cycle after reset is blanked
    car_present = 4'b0001;
    rst = 1'b1;
    pulse();
    check("blank_after_reset", state, 0);
    cyc(3);

    // Single approach: 0 -> 1 -> 3 -> 0
    push(4'd1, 4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0); pulse(); cyc(4);
    push(4'd3, 4'b0000, 4'b0001, 4'b1110, 2'd0, 1'b0); pulse(); cyc(4);
    push(4'd0, 4'b0000, 4'b0000, 4'hF,    2'd0, 1'b0); pulse(); cyc(4);

    // Skip empty approaches; dir1 primary, dir3 extended
    car_present = 4'b1010;
    heavy       = 4'b1000;
    push(4'd4,  4'b0010, 4'b0000, 4'b1101, 2'd1, 1'b0); pulse(); cyc(4);
    push(4'd6,  4'b0000, 4'b0010, 4'b1101, 2'd1, 1'b0); pulse(); cyc(4);
    push(4'd0,  4'b0000, 4'b0000, 4'hF,    2'd1, 1'b0); pulse(); cyc(4);
    push(4'd11, 4'b1000, 4'b0000, 4'b0111, 2'd3, 1'b0); pulse(); cyc(4);
    push(4'd12, 4'b0000, 4'b1000, 4'b0111, 2'd3, 1'b0); pulse(); cyc(4);
    push(4'd0,  4'b0000, 4'b0000, 4'hF,    2'd3, 1'b0); pulse(); cyc(4);

    // No cars with expired every cycle: stays all-red, no fault
    car_present = 4'b0000;
    heavy       = 4'b0000;
    expired     = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (i % 10 == 9) begin
        check("idle_state", state, 0);
        check("idle_red", red, 4'hF);
      end
    end
    expired = 1'b0;
    check("idle_fault", fault, 0);

    // expired held into the cycle after a change is ignored
    car_present = 4'b0001;
    cyc(2);
    push(4'd1, 4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0);
    expired = 1'b1;
    cyc(2);
    expired = 1'b0;
    check("blank_hold", state, 1);
    cyc(3);
    check("blank_hold_later", state, 1);
    push(4'd3, 4'b0000, 4'b0001, 4'b1110, 2'd0, 1'b0); pulse(); cyc(4);
    push(4'd0, 4'b0000, 4'b0000, 4'hF,    2'd0, 1'b0); pulse(); cyc(4);

    // Watchdog: dir1 green held without expiry
    car_present = 4'b0010;
    push(4'd4, 4'b0010, 4'b0000, 4'b1101, 2'd1, 1'b0); pulse();
    cyc(62);
    check("wdog_not_yet_fault", fault, 0);
    check("wdog_not_yet_state", state, 4);
    push(4'd0, 4'b0000, 4'b0000, 4'hF, 2'd1, 1'b1);
    cyc(1);
    check("wdog_fault", fault, 1);
    car_present = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      pulse();
      cyc(3);
      check("fault_sticky_state", state, 0);
      check("fault_sticky_flag", fault, 1);
    end

    // Reset clears the fault
    rst = 1'b0;
    cyc(2);
    check("rst_clear_fault", fault, 0);
    check("rst_clear_red", red, 4'hF);
    rst = 1'b1;
    car_present = 4'b0001;
    cyc(2);

    // Reset in mid-phase wins over a simultaneous expiry
    push(4'd1, 4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0); pulse(); cyc(2);
    push(4'd0, 4'b0000, 4'b0000, 4'hF, 2'd0, 1'b0);
    rst = 1'b0;
    expired = 1'b1;
    cyc(1);
    expired = 1'b0;
    check("midrst_state", state, 0);
    check("midrst_green", green, 0);
    cyc(1);
    rst = 1'b1;
    cyc(2);

`ifdef EMERGENCY_PREEMPT_EN
    // Preemption from dir0 green to dir2 extended green, rr untouched
    push(4'd1, 4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0); pulse(); cyc(2);
    push(4'd3, 4'b0000, 4'b0001, 4'b1110, 2'd0, 1'b0);
    emg_req = 4'b0100;
    cyc(4);
    push(4'd0, 4'b0000, 4'b0000, 4'hF,    2'd0, 1'b0); pulse(); cyc(4);
    push(4'd8, 4'b0100, 4'b0000, 4'b1011, 2'd2, 1'b0); pulse();
    emg_req = 4'b0000;
    cyc(4);
    push(4'd9, 4'b0000, 4'b0100, 4'b1011, 2'd2, 1'b0); pulse(); cyc(4);
    push(4'd0, 4'b0000, 4'b0000, 4'hF,    2'd2, 1'b0); pulse(); cyc(4);
    car_present = 4'b0011;
    push(4'd4, 4'b0010, 4'b0000, 4'b1101, 2'd1, 1'b0); pulse(); cyc(4);
`endif

    cyc(3);
    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
